// File: rtl/instruction_sequencer.sv
// ----------------------------------------------------------------------------
// instruction_sequencer
//
// Front end for a single-cycle MIPS datapath. Owns the PC, fetches one 32-bit
// word per instruction from an instruction memory over a req/ready handshake,
// and presents it to the datapath for exactly one EXEC cycle. Because the
// datapath writes its register file every clock, a NOP is driven whenever no
// real instruction is being executed.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start             pulse: run from PC 0 (also restarts from HALT)
//   step              pulse: execute one instruction at the current PC
//   abort             level: stop a run at the next fetch or execute edge
//   imem_req/addr     fetch request and word address (addr = pc)
//   imem_ready/rdata  memory accept and data, valid in the same cycle
//   instruction       word to the datapath (NOP outside real EXEC cycles)
//   instr_valid       high in the cycle a real instruction is driven
//   pc                current program counter
//   busy / halted     state decodes: FETCH|EXEC / HALT
//   instr_count       retired instructions, saturating at all-ones
//
// Optional build macro SEQ_BREAKPOINT_EN adds bp_enable, bp_addr and the
// registered pulse bp_hit. A fetch entered with pc == bp_addr is suppressed
// (no request) and the sequencer returns to IDLE with pc left at bp_addr.
// A fetch entered through step never trips the breakpoint, so stepping off a
// breakpoint executes that instruction.
// ----------------------------------------------------------------------------
module instruction_sequencer #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          CNT_WIDTH  = 16,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  step,
  input  logic                  abort,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instruction,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  instr_count
`ifdef SEQ_BREAKPOINT_EN
  ,
  input  logic                  bp_enable,
  input  logic [ADDR_WIDTH-1:0] bp_addr,
  output logic                  bp_hit
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic MODE_RUN  = 1'b0;
  localparam logic MODE_STEP = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [31:0]           ir_q, ir_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic                  ir_is_halt;

`ifdef SEQ_BREAKPOINT_EN
  // bp_pend_q is the breakpoint verdict captured on entry to FETCH, so a
  // bp_addr change while waiting on memory cannot retrigger mid-transfer.
  logic bp_pend_q, bp_pend_d;
  logic bp_hit_q, bp_hit_d;
`endif

  assign pc_inc     = pc_q + PC_ONE;
  assign ir_is_halt = (ir_q == HALT_INSTR);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    mode_d  = mode_q;
`ifdef SEQ_BREAKPOINT_EN
    bp_pend_d = bp_pend_q;
    bp_hit_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE, S_HALT: begin
        // start wins over step; HALT only responds to start.
        if (start) begin
          pc_d    = '0;
          cnt_d   = '0;
          mode_d  = MODE_RUN;
          state_d = S_FETCH;
`ifdef SEQ_BREAKPOINT_EN
          bp_pend_d = bp_enable && (bp_addr == '0);
`endif
        end else if (step && (state_q == S_IDLE)) begin
          mode_d  = MODE_STEP;
          state_d = S_FETCH;
`ifdef SEQ_BREAKPOINT_EN
          bp_pend_d = 1'b0;
`endif
        end
      end
      S_FETCH: begin
        if (abort) begin
          state_d = S_IDLE;
`ifdef SEQ_BREAKPOINT_EN
          bp_pend_d = 1'b0;
        end else if (bp_pend_q) begin
          state_d   = S_IDLE;
          bp_pend_d = 1'b0;
          bp_hit_d  = 1'b1;
`endif
        end else if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_EXEC;
`ifdef SEQ_BREAKPOINT_EN
          bp_pend_d = 1'b0;
`endif
        end
      end
      S_EXEC: begin
        if (ir_is_halt) begin
          state_d = S_HALT;
        end else begin
          pc_d = pc_inc;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
          if ((mode_q == MODE_STEP) || abort) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FETCH;
`ifdef SEQ_BREAKPOINT_EN
            bp_pend_d = bp_enable && (pc_inc == bp_addr);
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      ir_q    <= NOP_INSTR;
      mode_q  <= MODE_RUN;
`ifdef SEQ_BREAKPOINT_EN
      bp_pend_q <= 1'b0;
      bp_hit_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      mode_q  <= mode_d;
`ifdef SEQ_BREAKPOINT_EN
      bp_pend_q <= bp_pend_d;
      bp_hit_q  <= bp_hit_d;
`endif
    end
  end

  // Outputs are pure state decodes so a reset edge clears them all at once.
`ifdef SEQ_BREAKPOINT_EN
  assign imem_req = (state_q == S_FETCH) && !bp_pend_q;
  assign bp_hit   = bp_hit_q;
`else
  assign imem_req = (state_q == S_FETCH);
`endif
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_EXEC) && !ir_is_halt;
  assign instruction = instr_valid ? ir_q : NOP_INSTR;
  assign pc          = pc_q;
  assign busy        = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign halted      = (state_q == S_HALT);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
module tb_instruction_sequencer;

  localparam logic [31:0] W0 = 32'h2008_0005;
  localparam logic [31:0] W1 = 32'h2009_0003;
  localparam logic [31:0] W2 = 32'h0109_5020;
  localparam logic [31:0] WH = 32'hFFFF_FFFF;
  localparam logic [31:0] NP = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT, ADDR_WIDTH=8
  logic        rst = 1'b1, start = 1'b0, step = 1'b0, abort = 1'b0, rdy = 1'b1;
  logic        req, vld, busy, halted;
  logic [7:0]  addr, pc;
  logic [31:0] rdata, instr;
  logic [15:0] cnt;

  // wrap DUT, ADDR_WIDTH=2
  logic        w_rst = 1'b1, w_start = 1'b0, w_abort = 1'b0;
  logic        w_req, w_vld, w_busy, w_halted;
  logic [1:0]  w_addr, w_pc;
  logic [31:0] w_rdata, w_instr;
  logic [15:0] w_cnt;

`ifdef SEQ_BREAKPOINT_EN
  logic       bp_enable = 1'b0;
  logic [7:0] bp_addr = 8'd0;
  logic       bp_hit;
  logic       w_bp_hit;
`endif

  function automatic logic [31:0] rom_main(input logic [7:0] a);
    case (a)
      8'd0:    return W0;
      8'd1:    return W1;
      8'd2:    return W2;
      8'd3:    return WH;
      default: return NP;
    endcase
  endfunction

  function automatic logic [31:0] rom_wrap(input logic [1:0] a);
    case (a)
      2'd0:    return 32'h1111_1111;
      2'd1:    return 32'h2222_2222;
      2'd2:    return 32'h3333_3333;
      default: return 32'h4444_4444;
    endcase
  endfunction

  assign rdata   = rom_main(addr);
  assign w_rdata = rom_wrap(w_addr);

  instruction_sequencer dut (
    .clk(clk), .reset(rst), .start(start), .step(step), .abort(abort),
    .imem_req(req), .imem_addr(addr), .imem_ready(rdy), .imem_rdata(rdata),
    .instruction(instr), .instr_valid(vld), .pc(pc), .busy(busy),
    .halted(halted), .instr_count(cnt)
`ifdef SEQ_BREAKPOINT_EN
    , .bp_enable(bp_enable), .bp_addr(bp_addr), .bp_hit(bp_hit)
`endif
  );

  instruction_sequencer #(.ADDR_WIDTH(2)) dut_w (
    .clk(clk), .reset(w_rst), .start(w_start), .step(1'b0), .abort(w_abort),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(1'b1), .imem_rdata(w_rdata),
    .instruction(w_instr), .instr_valid(w_vld), .pc(w_pc), .busy(w_busy),
    .halted(w_halted), .instr_count(w_cnt)
`ifdef SEQ_BREAKPOINT_EN
    , .bp_enable(1'b0), .bp_addr(2'd0), .bp_hit(w_bp_hit)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic st, sp, ab, rd;
    logic req; logic [7:0] addr; logic [31:0] instr;
    logic vld, busy, halt; logic [7:0] pc; logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic st, sp, ab, rd, e_req,
                              input logic [7:0] e_addr, input logic [31:0] e_instr,
                              input logic e_vld, e_busy, e_halt,
                              input logic [7:0] e_pc, input logic [15:0] e_cnt);
    vec_t v;
    v.st = st; v.sp = sp; v.ab = ab; v.rd = rd;
    v.req = e_req; v.addr = e_addr; v.instr = e_instr;
    v.vld = e_vld; v.busy = e_busy; v.halt = e_halt; v.pc = e_pc; v.cnt = e_cnt;
    return v;
  endfunction

  // Watch n cycles starting with the current one; ends on a later negedge.
  task automatic watch(input int n, output int nv, output logic [31:0] last,
                       output int nhit, output int nreq2);
    nv = 0; last = NP; nhit = 0; nreq2 = 0;
    for (int k = 0; k < n; k++) begin
      #1;
      if (vld) begin nv++; last = instr; end
      if (req && addr == 8'd2) nreq2++;
`ifdef SEQ_BREAKPOINT_EN
      if (bp_hit) nhit++;
`endif
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_step();
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  vec_t tbl[23];
  int nv, nhit, nreq2, n;
  logic [31:0] last;
  logic [31:0] got[6];

  initial begin
    // cols: start step abort ready | req addr instr valid busy halted pc count
    tbl[0]  = mk(1,0,0,1, 0,0,NP,0,0,0,0,0);
    tbl[1]  = mk(0,0,0,1, 1,0,NP,0,1,0,0,0);
    tbl[2]  = mk(0,0,0,1, 0,0,W0,1,1,0,0,0);
    tbl[3]  = mk(0,0,0,1, 1,1,NP,0,1,0,1,1);
    tbl[4]  = mk(0,0,0,1, 0,1,W1,1,1,0,1,1);
    tbl[5]  = mk(0,0,0,1, 1,2,NP,0,1,0,2,2);
    tbl[6]  = mk(0,0,0,1, 0,2,W2,1,1,0,2,2);
    tbl[7]  = mk(0,0,0,1, 1,3,NP,0,1,0,3,3);
    tbl[8]  = mk(0,0,0,1, 0,3,NP,0,1,0,3,3);
    tbl[9]  = mk(0,1,1,1, 0,3,NP,0,0,1,3,3);
    tbl[10] = mk(1,0,0,1, 0,3,NP,0,0,1,3,3);
    tbl[11] = mk(0,0,0,1, 1,0,NP,0,1,0,0,0);
    tbl[12] = mk(0,0,0,1, 0,0,W0,1,1,0,0,0);
    tbl[13] = mk(0,0,0,0, 1,1,NP,0,1,0,1,1);
    tbl[14] = mk(1,0,0,0, 1,1,NP,0,1,0,1,1);
    tbl[15] = mk(0,1,0,0, 1,1,NP,0,1,0,1,1);
    tbl[16] = mk(0,0,0,1, 1,1,NP,0,1,0,1,1);
    tbl[17] = mk(0,0,0,1, 0,1,W1,1,1,0,1,1);
    tbl[18] = mk(0,0,0,1, 1,2,NP,0,1,0,2,2);
    tbl[19] = mk(0,0,0,1, 0,2,W2,1,1,0,2,2);
    tbl[20] = mk(0,0,0,1, 1,3,NP,0,1,0,3,3);
    tbl[21] = mk(0,0,0,1, 0,3,NP,0,1,0,3,3);
    tbl[22] = mk(0,0,0,1, 0,3,NP,0,0,1,3,3);

    repeat (2) @(negedge clk);
    rst = 1'b0; w_rst = 1'b0;

    // Run from zero to HALT, restart from HALT, then wait states on addr 1.
    foreach (tbl[i]) begin
      @(negedge clk);
      start = tbl[i].st; step = tbl[i].sp; abort = tbl[i].ab; rdy = tbl[i].rd;
      #1;
      chk($sformatf("v%0d.req", i),   req,    tbl[i].req);
      chk($sformatf("v%0d.addr", i),  addr,   tbl[i].addr);
      chk($sformatf("v%0d.instr", i), instr,  tbl[i].instr);
      chk($sformatf("v%0d.valid", i), vld,    tbl[i].vld);
      chk($sformatf("v%0d.busy", i),  busy,   tbl[i].busy);
      chk($sformatf("v%0d.halted", i), halted, tbl[i].halt);
      chk($sformatf("v%0d.pc", i),    pc,     tbl[i].pc);
      chk($sformatf("v%0d.count", i), cnt,    tbl[i].cnt);
    end
    start = 1'b0; step = 1'b0; abort = 1'b0; rdy = 1'b1;

    // Single-step twice from pc 0.
    do_reset();
    pulse_step();
    watch(5, nv, last, nhit, nreq2);
    chk("step1.pulses", nv, 1);
    chk("step1.instr", last, W0);
    chk("step1.pc", pc, 1);
    chk("step1.busy", busy, 0);
    pulse_step();
    watch(5, nv, last, nhit, nreq2);
    chk("step2.pulses", nv, 1);
    chk("step2.instr", last, W1);
    chk("step2.pc", pc, 2);
    chk("step2.count", cnt, 2);

    // Abort during a stalled fetch of addr 2, then step executes addr 2.
    do_reset();
    pulse_start();
    watch(4, nv, last, nhit, nreq2);
    rdy = 1'b0;
    #1;
    chk("abort.pre_req", req, 1);
    chk("abort.pre_addr", addr, 2);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    #1;
    chk("abort.req", req, 0);
    chk("abort.busy", busy, 0);
    chk("abort.pc", pc, 2);
    chk("abort.count", cnt, 2);
    rdy = 1'b1;
    pulse_step();
    watch(4, nv, last, nhit, nreq2);
    chk("abort.step_pulses", nv, 1);
    chk("abort.step_instr", last, W2);
    chk("abort.step_pc", pc, 3);
    chk("abort.step_count", cnt, 3);

    // start and step together: start wins (full run from 0).
    @(negedge clk); start = 1'b1; step = 1'b1;
    @(negedge clk); start = 1'b0; step = 1'b0;
    watch(12, nv, last, nhit, nreq2);
    chk("both.pulses", nv, 3);
    chk("both.halted", halted, 1);
    chk("both.count", cnt, 3);

    // Reset during an EXEC cycle.
    do_reset();
    pulse_start();
    watch(3, nv, last, nhit, nreq2);
    #1;
    chk("rexec.pre_valid", vld, 1);
    chk("rexec.pre_pc", pc, 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rexec.req", req, 0);
    chk("rexec.addr", addr, 0);
    chk("rexec.instr", instr, NP);
    chk("rexec.valid", vld, 0);
    chk("rexec.busy", busy, 0);
    chk("rexec.halted", halted, 0);
    chk("rexec.pc", pc, 0);
    chk("rexec.count", cnt, 0);

    // PC wrap on a 2-bit-address instance: 6 instructions then abort.
    @(negedge clk); w_start = 1'b1;
    @(negedge clk); w_start = 1'b0;
    n = 0;
    for (int k = 0; k < 40 && n < 6; k++) begin
      #1;
      if (w_vld) begin
        got[n] = w_instr;
        n++;
        if (n == 6) w_abort = 1'b1;
      end
      @(negedge clk);
    end
    w_abort = 1'b0;
    #1;
    chk("wrap.pulses", n, 6);
    if (n == 6) begin
      chk("wrap.instr3", got[3], 32'h4444_4444);
      chk("wrap.instr4", got[4], 32'h1111_1111);
      chk("wrap.instr5", got[5], 32'h2222_2222);
    end
    chk("wrap.pc", w_pc, 2);
    chk("wrap.count", w_cnt, 6);
    chk("wrap.busy", w_busy, 0);
    chk("wrap.halted", w_halted, 0);

`ifdef SEQ_BREAKPOINT_EN
    // Breakpoint at addr 2: run stops before fetching it, step executes it.
    do_reset();
    #1;
    chk("bp.reset_hit", bp_hit, 0);
    bp_addr = 8'd2; bp_enable = 1'b1;
    pulse_start();
    watch(10, nv, last, nhit, nreq2);
    chk("bp.run_pulses", nv, 2);
    chk("bp.hits", nhit, 1);
    chk("bp.req_addr2", nreq2, 0);
    chk("bp.busy", busy, 0);
    chk("bp.pc", pc, 2);
    pulse_step();
    watch(5, nv, last, nhit, nreq2);
    chk("bp.step_pulses", nv, 1);
    chk("bp.step_instr", last, W2);
    chk("bp.step_hits", nhit, 0);
    chk("bp.step_pc", pc, 3);
    bp_enable = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Sequences the single-cycle MIPS datapath: owns the PC, fetches 32-bit words from an instruction memory over a req/ready handshake, and presents exactly one instruction per execute cycle to the datapath `instruction` input.
- The datapath writes its register file every clock, so outside execute cycles the block drives a harmless NOP.
- Supports run-from-zero, single-step, abort and a HALT encoding.

Parameters:
- ADDR_WIDTH, 8, word-address width of PC / imem_addr.
- CNT_WIDTH, 16, width of retired-instruction counter.
- NOP_INSTR, 32'h0000_0000, word driven when not executing (sll $0,$0,0).
- HALT_INSTR, 32'hFFFF_FFFF, encoding that stops the sequencer.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  pulse: run from PC 0.
- step  input  1  pulse: execute one instruction from current PC.
- abort  input  1  level: stop run at next safe point.
- imem_req  output  1  fetch request.
- imem_addr  output  ADDR_WIDTH  fetch word address (= pc).
- imem_ready  input  1  memory accepts; imem_rdata valid same cycle.
- imem_rdata  input  32  fetched word.
- instruction  output  32  to datapath instruction input.
- instr_valid  output  1  high in the cycle a real instruction is driven.
- pc  output  ADDR_WIDTH  current program counter.
- busy  output  1  high in FETCH or EXEC.
- halted  output  1  high in HALT.
- instr_count  output  CNT_WIDTH  retired instructions, saturating.

Behaviour:
- Reset:
  - Values: state=IDLE, pc=0, instr_count=0, ir=NOP_INSTR, imem_req=0, instr_valid=0, instruction=NOP_INSTR, busy=0, halted=0, mode=RUN.
  - Reset mid-fetch or mid-exec discards the transfer and takes effect next edge.
- States: IDLE, FETCH, EXEC, HALT. imem_req, busy and halted are decoded from state. instruction = ir only in EXEC with ir != HALT_INSTR, else NOP_INSTR.
- IDLE:
  - start: pc<=0, instr_count<=0, mode<=RUN, go FETCH.
  - else step: mode<=STEP, pc kept, go FETCH.
  - start and step together: start wins.
- FETCH:
  - imem_req=1, imem_addr=pc, held stable until a rising edge with imem_ready=1. On that edge ir<=imem_rdata, go EXEC.
  - abort=1 at the edge (priority over ready) drops req and goes IDLE; pc unchanged, ir unchanged.
- EXEC (exactly one cycle):
  - ir==HALT_INSTR: instruction=NOP, instr_valid=0, pc and count unchanged, go HALT.
  - else: instr_valid=1, pc<=pc+1, wrapping modulo 2^ADDR_WIDTH with no special action. instr_count<=instr_count+1, saturating at all-ones.
  - Next state: IDLE if mode=STEP or abort=1, else FETCH.
- HALT:
  - start restarts as from IDLE. step and abort are ignored. Only start or reset leaves.
- start/step arriving in FETCH/EXEC is ignored (not queued).
- Latency:
  - start at edge N puts req high in cycle N+1. With ready in N+1, the instruction is driven in cycle N+2.
  - Steady-state throughput is 1 instruction per 2 cycles with zero-wait memory. Each wait cycle adds 1.

Optional Feature:
- Macro SEQ_BREAKPOINT_EN.
- When defined, adds ports:
  - bp_enable input 1.
  - bp_addr input ADDR_WIDTH.
  - bp_hit output 1 (registered, one-cycle pulse, reset 0).
- In FETCH (mode RUN or STEP), if bp_enable=1 and pc==bp_addr on entry to FETCH, the block:
  - issues no request: imem_req stays 0;
  - moves FETCH->IDLE on the next edge;
  - pulses bp_hit for one cycle.
- pc stays at bp_addr. A subsequent step executes that instruction without re-triggering: the breakpoint is ignored for the first fetch after a step.
- When undefined, the ports are absent and behaviour is exactly as above.

Test Plan:
- Reset, then start; ROM 0:0x20080005, 1:0x20090003, 2:0x01095020, 3:0xFFFFFFFF, ready tied 1 -> instr_valid pulses in cycles 2,4,6 with those words; halted=1 after; pc=3; instr_count=3; instruction=0 outside the pulses.
- Same ROM, imem_ready low for 3 cycles on the fetch at addr 1 -> imem_req and imem_addr=1 held stable 4 cycles; instruction stays 0x00000000 meanwhile; final instr_count=3.
- From IDLE with pc=0, two step pulses spaced 5 cycles -> each gives exactly one instr_valid pulse; pc=1, then 2; busy low between them.
- abort raised during FETCH of addr 2 with ready low -> imem_req drops next edge, state IDLE, pc=2, instr_count=2; a following step executes addr 2.
- ADDR_WIDTH=2, ROM of 4 non-halt words, run 6 instructions -> pc wraps 3->0; instr_count=6. Reset asserted in an EXEC cycle -> all outputs return to reset values the next cycle.
- SEQ_BREAKPOINT_EN, bp_addr=2, bp_enable=1, start -> addrs 0,1 execute; bp_hit pulses once; no request to addr 2; state IDLE, pc=2. A step then executes addr 2 with no bp_hit.
